// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared stall polarity and state encodings for pipe_stage_buf
package pipe_stage_buf_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // occupancy is driven straight from the state, so the encoding is the entry count
  typedef enum logic [1:0] {
    PSB_EMPTY = 2'd0,
    PSB_FULL  = 2'd1,
    PSB_SKID  = 2'd2
  } psb_state_e;

endpackage

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - inter-stage buffer with valid/ready, optional skid entry and flush
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int              DATA_W    = 64,
  parameter int              DEPTH     = 1,
  parameter int              STALL_W   = 6,
  parameter int              STAGE     = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  psb_state_e        state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt, skid_q;
  logic              accept, issue;
  logic              unused_stall;

  assign unused_stall = ^stall;

  assign out_valid = (state != PSB_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

  assign issue  = out_valid & out_ready & (stall[STAGE+1] == NO_STOP);
  assign accept = in_valid & in_ready & (stall[STAGE] == NO_STOP);

  generate
    if (DEPTH == 2) begin : g_skid
      // in_ready depends only on the state register, cutting the out_ready/stall path
      assign in_ready = (state != PSB_SKID);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          skid_q <= NOP_VALUE;
        else if (flush)
          skid_q <= NOP_VALUE;
        else if (state == PSB_FULL && accept && !issue)
          skid_q <= in_data;
        else if (state == PSB_SKID && issue)
          skid_q <= NOP_VALUE;
      end
    end else begin : g_noskid
      assign in_ready = (state == PSB_EMPTY) | issue;
      assign skid_q   = NOP_VALUE;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    case (state)
      PSB_EMPTY: begin
        if (accept) begin
          state_nxt = PSB_FULL;
          main_nxt  = in_data;
        end
      end
      PSB_FULL: begin
        if (issue && accept) begin
          main_nxt = in_data;
        end else if (issue) begin
          state_nxt = PSB_EMPTY;
          main_nxt  = NOP_VALUE;
        end else if (accept) begin
          state_nxt = (DEPTH == 2) ? PSB_SKID : PSB_FULL;
        end
      end
      PSB_SKID: begin
        if (issue) begin
          state_nxt = PSB_FULL;
          main_nxt  = skid_q;
        end
      end
      default: begin
        state_nxt = PSB_EMPTY;
        main_nxt  = NOP_VALUE;
      end
    endcase
    // flush wins over any handshake in the same cycle
    if (flush) begin
      state_nxt = PSB_EMPTY;
      main_nxt  = NOP_VALUE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= PSB_EMPTY;
      main_q <= NOP_VALUE;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - bench for pipe_stage_buf, DEPTH=1 and DEPTH=2 instances on shared stimulus
module tb_pipe_stage_buf;

  localparam logic [15:0] NOP1 = 16'h0000;
  localparam logic [15:0] NOP2 = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic        ir1, ov1, ir2, ov2;
  logic [15:0] od1, od2;
  logic [1:0]  occ1, occ2;

  int checks = 0;
  int failures = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(16), .DEPTH(1), .STALL_W(6), .STAGE(2), .NOP_VALUE(NOP1)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1));

  pipe_stage_buf #(.DATA_W(16), .DEPTH(2), .STALL_W(6), .STAGE(2), .NOP_VALUE(NOP2)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(occ2));

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic [5:0]  st;
    logic        fl;
    logic        e_ov;
    logic [15:0] e_od;
    logic [1:0]  e_occ;
    logic        e_ir;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // queue model: entries pushed on accept, popped and compared on issue
  task automatic model_step(input int k);
    int          sz;
    logic [15:0] head, nop, a_od;
    logic        e_ov, iss, e_ir, acc, a_ov, a_ir;
    logic [1:0]  a_occ;
    string       t;
    nop = (k == 1) ? NOP1 : NOP2;
    sz  = (k == 1) ? q1.size() : q2.size();
    if (sz > 0) head = (k == 1) ? q1[0] : q2[0];
    else        head = nop;
    e_ov = (sz > 0);
    iss  = e_ov & out_ready & ~stall[3];
    e_ir = (k == 1) ? ((sz == 0) | iss) : (sz < 2);
    acc  = in_valid & e_ir & ~stall[2];
    a_ov  = (k == 1) ? ov1 : ov2;
    a_od  = (k == 1) ? od1 : od2;
    a_occ = (k == 1) ? occ1 : occ2;
    a_ir  = (k == 1) ? ir1 : ir2;
    t = (k == 1) ? "d1" : "d2";
    chk({t, "_out_valid"}, 32'(a_ov), 32'(e_ov));
    chk({t, "_out_data"}, 32'(a_od), 32'(head));
    chk({t, "_occupancy"}, 32'(a_occ), 32'(sz));
    chk({t, "_in_ready"}, 32'(a_ir), 32'(e_ir));
    if (flush) begin
      if (k == 1) q1.delete(); else q2.delete();
    end else begin
      if (iss) begin
        if (k == 1) void'(q1.pop_front()); else void'(q2.pop_front());
      end
      if (acc) begin
        if (k == 1) q1.push_back(in_data); else q2.push_back(in_data);
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [15:0] d, input logic r,
                       input logic [5:0] st, input logic fl);
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r; stall = st; flush = fl;
    #1;
    model_step(1);
    model_step(2);
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    //                v   d       r   st          fl    ov  od     occ  ir
    vecs[0]  = '{1'b1, 16'h11, 1'b0, 6'b000000, 1'b0, 1'b0, NOP2,  2'd0, 1'b1};
    vecs[1]  = '{1'b1, 16'h22, 1'b0, 6'b000000, 1'b0, 1'b1, 16'h11, 2'd1, 1'b1};
    vecs[2]  = '{1'b1, 16'h99, 1'b0, 6'b000000, 1'b0, 1'b1, 16'h11, 2'd2, 1'b0};
    vecs[3]  = '{1'b0, 16'h00, 1'b1, 6'b000000, 1'b0, 1'b1, 16'h11, 2'd2, 1'b0};
    vecs[4]  = '{1'b0, 16'h00, 1'b1, 6'b000000, 1'b0, 1'b1, 16'h22, 2'd1, 1'b1};
    vecs[5]  = '{1'b1, 16'h33, 1'b0, 6'b000000, 1'b0, 1'b0, NOP2,  2'd0, 1'b1};
    vecs[6]  = '{1'b1, 16'h77, 1'b1, 6'b001111, 1'b0, 1'b1, 16'h33, 2'd1, 1'b1};
    vecs[7]  = '{1'b1, 16'h77, 1'b1, 6'b000111, 1'b0, 1'b1, 16'h33, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 16'h00, 1'b1, 6'b000000, 1'b0, 1'b0, NOP2,  2'd0, 1'b1};
    vecs[9]  = '{1'b1, 16'h44, 1'b0, 6'b000000, 1'b0, 1'b0, NOP2,  2'd0, 1'b1};
    vecs[10] = '{1'b1, 16'h55, 1'b0, 6'b000000, 1'b0, 1'b1, 16'h44, 2'd1, 1'b1};
    vecs[11] = '{1'b1, 16'h66, 1'b0, 6'b000000, 1'b1, 1'b1, 16'h44, 2'd2, 1'b0};
    vecs[12] = '{1'b0, 16'h00, 1'b1, 6'b000000, 1'b0, 1'b0, NOP2,  2'd0, 1'b1};
    vecs[13] = '{1'b0, 16'h00, 1'b1, 6'b000000, 1'b0, 1'b0, NOP2,  2'd0, 1'b1};

    @(negedge clk); @(negedge clk); #1;
    chk("rst_ov1", 32'(ov1), 32'd0);
    chk("rst_od1", 32'(od1), 32'(NOP1));
    chk("rst_occ2", 32'(occ2), 32'd0);
    chk("rst_od2", 32'(od2), 32'(NOP2));
    @(negedge clk); rst = 1'b1; #1;
    chk("rel_ir1", 32'(ir1), 32'd1);
    chk("rel_ir2", 32'(ir2), 32'd1);

    for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b1, 6'd0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 6'd0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 6'd0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].st, vecs[i].fl);
      chk($sformatf("vec%0d_ov", i), 32'(ov2), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_od", i), 32'(od2), 32'(vecs[i].e_od));
      chk($sformatf("vec%0d_occ", i), 32'(occ2), 32'(vecs[i].e_occ));
      chk($sformatf("vec%0d_ir", i), 32'(ir2), 32'(vecs[i].e_ir));
    end

    cycle(1'b1, 16'hAA, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("mid_pre_od1", 32'(od1), 32'h00AA);
    chk("mid_pre_od2", 32'(od2), 32'h00AA);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ov1", 32'(ov1), 32'd0);
    chk("mid_rst_od1", 32'(od1), 32'(NOP1));
    chk("mid_rst_ov2", 32'(ov2), 32'd0);
    chk("mid_rst_od2", 32'(od2), 32'(NOP2));
    chk("mid_rst_occ2", 32'(occ2), 32'd0);
    q1.delete();
    q2.delete();
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_rel_ir1", 32'(ir1), 32'd1);
    chk("mid_rel_ir2", 32'(ir2), 32'd1);

    for (int n = 0; n < 10000; n++) begin
      cycle(1'($urandom), 16'($urandom), 1'($urandom),
            (($urandom % 4) == 0) ? 6'($urandom) : 6'd0,
            (($urandom % 16) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
